mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port of the multi-cycle MIPS core between two requesters.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/arb_starve_counter.sv | 36 +++
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_LOADER = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    // Core wins ties unless the loader has been starved long enough.
    function automatic owner_t pick_owner(input logic req0, input logic req1, input logic starved);
        if (req1 && (!req0 || starved)) begin
            return OWN_LOADER;
        end
        return OWN_CORE;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of arbitrations the loader lost; at_max forces its next win.
module arb_starve_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int unsigned CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt != CW'(MAX))) begin
            cnt_d = cnt + CW'(1);
        end
    end

    // at_max is registered alongside the count so it always equals (cnt == MAX).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else begin
            cnt    <= cnt_d;
            at_max <= (cnt_d == CW'(MAX));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the core's single memory port: one outstanding access,
// starvation guard for the loader, and an access timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          core_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata
);
    localparam int unsigned   TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;
    owner_t        owner;
    owner_t        win;
    logic [TW-1:0] tcnt;
    logic          starved;
    logic          timeout_hit;
    logic          grant;
    logic          done_ok;
    logic          done_to;
    logic          starve_inc;
    logic          starve_clr;

    assign win         = pick_owner(req0, req1, starved);
    assign timeout_hit = (TIMEOUT != 0) && (tcnt == T_LAST);

    // Stall is the one combinational output: the core must freeze in the same cycle it asks.
    assign core_stall  = req0 & ~rvalid0;

    arb_starve_counter #(
        .MAX    (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starved)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // mem_ready wins over timeout on the last cycle, so a late completion is not reported as an error.
    always_comb begin
        grant      = (state == IDLE) && (req0 || req1);
        done_ok    = (state == ACCESS) && mem_ready;
        done_to    = (state == ACCESS) && !mem_ready && timeout_hit;
        starve_inc = grant && (win == OWN_CORE) && req1;
        starve_clr = grant && (win == OWN_LOADER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_CORE;
            tcnt      <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            gnt0    <= grant && (win == OWN_CORE);
            gnt1    <= grant && (win == OWN_LOADER);
            rvalid0 <= (done_ok || done_to) && (owner == OWN_CORE);
            rvalid1 <= (done_ok || done_to) && (owner == OWN_LOADER);
            mem_req <= (state_nxt == ACCESS);

            if (grant) begin
                owner     <= win;
                tcnt      <= '0;
                mem_we    <= (win == OWN_LOADER) ? we1    : we0;
                mem_addr  <= (win == OWN_LOADER) ? addr1  : addr0;
                mem_wdata <= (win == OWN_LOADER) ? wdata1 : wdata0;
            end else if (state == ACCESS) begin
                tcnt <= tcnt + TW'(1);
            end

            if (done_ok) begin
                rdata <= mem_rdata;
                err   <= 1'b0;
            end else if (done_to) begin
                rdata <= DW'(ERR_RDATA);
                err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard and corner-case sequences.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef struct {
        bit          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          exp_lat;
        int          exp_mcyc;
    } vec_t;

    typedef struct {
        bit          who;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, err, core_stall;
    logic [DW-1:0] rdata;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 0;
    int   mcnt     = 0;
    bit   stray    = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[6];
    bit   exp_order[10];

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .err(err), .core_stall(core_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    assign mem_rdata = mem_data(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: ready after 'lat' wait cycles, checks the latched command while mem_req is up.
    always @(negedge clk) begin
        if (!reset) begin
            mcnt      = 0;
            mem_ready = 1'b0;
        end else if (mem_req) begin
            if (exp_q.size() == 0) begin
                chk("mem_req_unexpected", 32'(mem_req), 32'd0);
            end else begin
                chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
                chk("mem_addr", mem_addr, exp_q[0].addr);
                if (exp_q[0].we) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
            end
            if (mcnt == lat) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = 1'b0;
                mcnt++;
            end
        end else begin
            mcnt      = 0;
            mem_ready = stray;
        end
    end

    // Scoreboard: every rvalid pops and compares the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (gnt0 && gnt1)       chk("gnt_both", 32'({gnt1, gnt0}), 32'd0);
            if (rvalid0 && rvalid1) chk("rvalid_both", 32'({rvalid1, rvalid0}), 32'd0);
            if (rvalid0 || rvalid1) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'({rvalid1, rvalid0}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rvalid_port", 32'(rvalid1), 32'(e.who));
                    chk("rdata", rdata, e.rdata);
                    chk("err", 32'(err), 32'(e.err));
                end
            end
        end
    end

    task automatic push_exp(input bit who, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] r, input logic e);
        exp_t x;
        x.who = who; x.we = w; x.addr = a; x.wdata = d; x.rdata = r; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic run_txn(input vec_t v);
        int cyc;
        int mcyc;
        bit done;
        lat = v.lat;
        if (!v.who) begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
            #1;
            chk("core_stall_req", 32'(core_stall), 32'd1);
        end else begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end
        step();
        chk("gnt_port", 32'({gnt1, gnt0}), v.who ? 32'd2 : 32'd1);
        push_exp(v.who, v.we, v.addr, v.wdata, v.rdata, v.err);
        if (v.who) req1 = 1'b0;
        cyc  = 1;
        mcyc = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            if (rvalid0 || rvalid1) begin
                done = 1'b1;
            end else begin
                if (mem_req) mcyc++;
                chk("core_stall_wait", 32'(core_stall), v.who ? 32'd0 : 32'd1);
                step();
                cyc++;
            end
        end
        chk("rvalid_seen", 32'(done), 32'd1);
        chk("req_to_rvalid", 32'(cyc), 32'(v.exp_lat));
        chk("mem_req_cycles", 32'(mcyc), 32'(v.exp_mcyc));
        chk("core_stall_done", 32'(core_stall), 32'd0);
        req0 = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // who we addr wdata lat rdata err exp_lat exp_mcyc
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1,   32'h1234_5678, 1'b0, 3, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 2,   32'h1234_5638, 1'b0, 4, 3};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 0,   32'h1234_5778, 1'b0, 2, 1};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         7,   32'hEDCB_A984, 1'b0, 9, 8};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         255, 32'hDEAD_BEEF, 1'b1, 9, 8};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         3,   32'h1234_5668, 1'b0, 5, 4};
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (3) step();
        chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_cmd", 32'(mem_we) | mem_addr | mem_wdata, 32'd0);
        chk("rst_core_stall", 32'(core_stall), 32'd0);
        #3 reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_txn(vecs[i]);

        // Stray mem_ready in IDLE, then a core request dropped right after its grant.
        stray = 1'b1;
        repeat (3) begin
            step();
            chk("stray_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        end
        stray = 1'b0;
        lat = 2; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h50;
        step();
        chk("t6_gnt", 32'({gnt1, gnt0}), 32'd1);
        push_exp(1'b0, 1'b0, 32'h50, 32'h0, 32'h1234_5628, 1'b0);
        req0 = 1'b0; we0 = 1'b1; addr0 = 32'h77;
        begin
            int w = 0;
            while (!rvalid0 && w < 20) begin step(); w++; end
            chk("t6_rvalid0", 32'(rvalid0), 32'd1);
        end
        repeat (2) step();

        // Asynchronous reset in the middle of a hung access.
        lat = 255; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h60;
        step();
        chk("t5_gnt", 32'({gnt1, gnt0}), 32'd1);
        push_exp(1'b0, 1'b0, 32'h60, 32'h0, 32'h0, 1'b0);
        repeat (3) step();
        chk("t5_mem_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t5_mem_req_async", 32'(mem_req), 32'd0);
        chk("t5_gnt_async", 32'({gnt1, gnt0}), 32'd0);
        chk("t5_rvalid_async", 32'({rvalid1, rvalid0}), 32'd0);
        exp_q.delete();
        req0 = 1'b0;
        repeat (2) step();
        #2 reset = 1'b1;
        repeat (4) begin
            step();
            chk("t5_idle_mem_req", 32'(mem_req), 32'd0);
            chk("t5_idle_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        end
        chk("t5_rdata_cleared", rdata, 32'd0);

        // Both requesters held: loader forced through after four core wins.
        lat = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h30;
        for (int g = 0; g < 10; g++) begin
            int w = 0;
            step();
            while (!(gnt0 || gnt1) && w < 10) begin step(); w++; end
            chk("t3_gnt_seen", 32'(gnt0 || gnt1), 32'd1);
            chk($sformatf("t3_order%0d", g), 32'({gnt1, gnt0}), exp_order[g] ? 32'd2 : 32'd1);
            if (exp_order[g]) push_exp(1'b1, 1'b0, 32'h30, 32'h0, 32'h1234_5648, 1'b0);
            else              push_exp(1'b0, 1'b0, 32'h20, 32'h0, 32'h1234_5658, 1'b0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (4) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
